// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC payload type, output stage states and index-width rule
package noc_pkg;

    typedef bit [63:0] noc_data_t;

    typedef enum logic {EMPTY, FULL} stage_t;

    function automatic int noc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/noc_ingress_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first request at or above ptr
module rr_picker
    import noc_pkg::*;
#(
    parameter int N = 4,
    localparam int W = noc_idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_vld,
    output logic [W-1:0] gnt_idx
);

    // scan downward so the candidate closest to ptr is written last and wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt_vld = 1'b1;
                gnt_idx = W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/noc_ingress_arbiter.sv
// noc_ingress_arbiter: round-robin share of one NoC ingress port among CPU channels
module noc_ingress_arbiter
    import noc_pkg::*;
#(
    parameter int CPU_NB = 4,
    localparam int IDX_W = noc_idx_w(CPU_NB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_cpu_to_noc_vld [CPU_NB],
    output logic              data_cpu_to_noc_rdy [CPU_NB],
    input  logic [63:0]       data_cpu_to_noc     [CPU_NB],
    output logic              noc_in_vld,
    input  logic              noc_in_rdy,
    output logic [63:0]       noc_in_data,
    output logic [IDX_W-1:0]  noc_in_src,
    output logic [31:0]       grant_cnt           [CPU_NB]
);

    logic [CPU_NB-1:0] req;
    logic              gnt_vld;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  nxt_ptr;
    logic              load_ok;
    logic              accept;
    stage_t            state_q;
    noc_data_t         data_q;
    logic [IDX_W-1:0]  src_q;

    // pack the per-CPU valids into a request vector for the picker
    always_comb begin
        for (int k = 0; k < CPU_NB; k++) req[k] = data_cpu_to_noc_vld[k];
    end

    rr_picker #(.N(CPU_NB)) u_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // handshake only with the winner, only when the output slot can take a beat
    always_comb begin
        load_ok = (state_q == EMPTY) || noc_in_rdy;
        accept  = rst_n && gnt_vld && load_ok;
        nxt_ptr = (gnt_idx == IDX_W'(CPU_NB - 1)) ? '0 : gnt_idx + 1'b1;
        for (int k = 0; k < CPU_NB; k++) data_cpu_to_noc_rdy[k] = accept && (gnt_idx == IDX_W'(k));
    end

    // one-entry output stage: fill on accept, empty on drain without refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= '0;
        end else if (accept) begin
            state_q <= FULL;
            data_q  <= data_cpu_to_noc[gnt_idx];
            src_q   <= gnt_idx;
        end else if (noc_in_rdy) begin
            state_q <= EMPTY;
        end
    end

    // round-robin pointer moves past the winner only on a real accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr <= '0;
        else if (accept) rr_ptr <= nxt_ptr;
    end

    assign noc_in_vld  = (state_q == FULL);
    assign noc_in_data = data_q;
    assign noc_in_src  = src_q;

    for (genvar i = 0; i < CPU_NB; i++) begin : g_cnt
        logic [31:0] cnt_q;
        // free-running per-CPU accept counter, wraps naturally
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt_q <= '0;
            else if (data_cpu_to_noc_rdy[i]) cnt_q <= cnt_q + 32'd1;
        end
        assign grant_cnt[i] = cnt_q;
    end

endmodule

// File: tb/tb_noc_ingress_arbiter.sv
// tb_noc_ingress_arbiter: directed scenario checks of the ingress arbiter
module tb_noc_ingress_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld  [4];
    logic        rdy  [4];
    logic [63:0] din  [4];
    logic        noc_in_vld;
    logic        noc_in_rdy = 1'b0;
    logic [63:0] noc_in_data;
    logic [1:0]  noc_in_src;
    logic [31:0] cnt  [4];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_ingress_arbiter #(.CPU_NB(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .data_cpu_to_noc_vld (vld),
        .data_cpu_to_noc_rdy (rdy),
        .data_cpu_to_noc     (din),
        .noc_in_vld          (noc_in_vld),
        .noc_in_rdy          (noc_in_rdy),
        .noc_in_data         (noc_in_data),
        .noc_in_src          (noc_in_src),
        .grant_cnt           (cnt)
    );

    function automatic logic [63:0] dval(input int i);
        return 64'hA5A5_0000_0000_0000 | 64'(i + 1);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        noc_in_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vld[i] = 1'b0;
            din[i] = dval(i);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        noc_in_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vld[i] = 1'b1;
            din[i] = dval(i);
        end
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdy[i] !== 1'b0) begin errors++; $display("FAIL reset_rdy[%0d] got %b exp 0", i, rdy[i]); end
            checks++;
            if (cnt[i] !== 32'd0) begin errors++; $display("FAIL reset_cnt[%0d] got %h exp 0", i, cnt[i]); end
        end
        checks++;
        if (noc_in_vld !== 1'b0 || noc_in_data !== 64'd0 || noc_in_src !== 2'd0) begin
            errors++; $display("FAIL reset_out got vld=%b data=%h src=%0d exp 0/0/0", noc_in_vld, noc_in_data, noc_in_src);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (noc_in_vld !== 1'b0) begin errors++; $display("FAIL release_vld got %b exp 0", noc_in_vld); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdy[i] !== (i == 0)) begin errors++; $display("FAIL release_rdy[%0d] got %b exp %b", i, rdy[i], i == 0); end
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (noc_in_vld !== 1'b1 || noc_in_src !== 2'(k % 4) || noc_in_data !== dval(k % 4)) begin
                errors++; $display("FAIL rr_beat%0d got vld=%b src=%0d data=%h exp 1/%0d/%h", k, noc_in_vld, noc_in_src, noc_in_data, k % 4, dval(k % 4));
            end
            #1;
            checks++;
            if (rdy[(k + 1) % 4] !== 1'b1) begin errors++; $display("FAIL rr_next_rdy%0d got %b exp 1", k, rdy[(k + 1) % 4]); end
        end
        for (int i = 0; i < 4; i++) vld[i] = 1'b0;
        @(negedge clk);
        checks++;
        if (noc_in_vld !== 1'b0 || noc_in_src !== 2'd1 || noc_in_data !== dval(1)) begin
            errors++; $display("FAIL rr_drain got vld=%b src=%0d data=%h exp 0/1/%h", noc_in_vld, noc_in_src, noc_in_data, dval(1));
        end
        checks++;
        if (cnt[0] !== 32'd2 || cnt[1] !== 32'd2 || cnt[2] !== 32'd1 || cnt[3] !== 32'd1) begin
            errors++; $display("FAIL rr_cnt got %0d,%0d,%0d,%0d exp 2,2,1,1", cnt[0], cnt[1], cnt[2], cnt[3]);
        end
    endtask

    task automatic test_single();
        do_reset();
        noc_in_rdy = 1'b1;
        vld[2] = 1'b1;
        din[2] = 64'hDEAD_BEEF_0000_0002;
        #1;
        checks++;
        if (rdy[2] !== 1'b1 || rdy[0] !== 1'b0) begin errors++; $display("FAIL single_rdy got rdy2=%b rdy0=%b exp 1/0", rdy[2], rdy[0]); end
        @(negedge clk);
        vld[2] = 1'b0;
        checks++;
        if (noc_in_vld !== 1'b1 || noc_in_src !== 2'd2 || noc_in_data !== 64'hDEAD_BEEF_0000_0002) begin
            errors++; $display("FAIL single_out got vld=%b src=%0d data=%h exp 1/2/deadbeef00000002", noc_in_vld, noc_in_src, noc_in_data);
        end
        checks++;
        if (cnt[2] !== 32'd1 || cnt[0] !== 32'd0) begin errors++; $display("FAIL single_cnt got c2=%0d c0=%0d exp 1/0", cnt[2], cnt[0]); end
    endtask

    task automatic test_backpressure();
        do_reset();
        noc_in_rdy = 1'b1;
        for (int i = 0; i < 4; i++) vld[i] = 1'b1;
        @(negedge clk);
        noc_in_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (noc_in_vld !== 1'b1 || noc_in_src !== 2'd0 || noc_in_data !== dval(0)) begin
                errors++; $display("FAIL hold%0d got vld=%b src=%0d data=%h exp 1/0/%h", k, noc_in_vld, noc_in_src, noc_in_data, dval(0));
            end
            checks++;
            if (rdy[0] | rdy[1] | rdy[2] | rdy[3]) begin
                errors++; $display("FAIL hold_rdy%0d got %b%b%b%b exp 0000", k, rdy[3], rdy[2], rdy[1], rdy[0]);
            end
            checks++;
            if (cnt[0] !== 32'd1 || cnt[1] !== 32'd0) begin errors++; $display("FAIL hold_cnt%0d got c0=%0d c1=%0d exp 1/0", k, cnt[0], cnt[1]); end
        end
        noc_in_rdy = 1'b1;
        #1;
        checks++;
        if (rdy[1] !== 1'b1) begin errors++; $display("FAIL resume_rdy got %b exp 1", rdy[1]); end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (noc_in_vld !== 1'b1 || noc_in_src !== 2'(k)) begin
                errors++; $display("FAIL resume%0d got vld=%b src=%0d exp 1/%0d", k, noc_in_vld, noc_in_src, k);
            end
        end
        for (int i = 0; i < 4; i++) vld[i] = 1'b0;
    endtask

    task automatic test_skip();
        logic [1:0] exp_src [3];
        exp_src[0] = 2'd3;
        exp_src[1] = 2'd1;
        exp_src[2] = 2'd3;
        do_reset();
        noc_in_rdy = 1'b1;
        vld[1] = 1'b1;
        @(negedge clk);
        vld[3] = 1'b1;
        #1;
        checks++;
        if (rdy[3] !== 1'b1 || rdy[1] !== 1'b0) begin errors++; $display("FAIL skip_first got rdy3=%b rdy1=%b exp 1/0", rdy[3], rdy[1]); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (noc_in_vld !== 1'b1 || noc_in_src !== exp_src[k]) begin
                errors++; $display("FAIL skip%0d got vld=%b src=%0d exp 1/%0d", k, noc_in_vld, noc_in_src, exp_src[k]);
            end
        end
        vld[1] = 1'b0;
        vld[3] = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        vld[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (noc_in_vld !== 1'b1 || cnt[0] !== 32'd1) begin errors++; $display("FAIL mid_pre got vld=%b c0=%0d exp 1/1", noc_in_vld, cnt[0]); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (noc_in_vld !== 1'b0 || noc_in_data !== 64'd0) begin errors++; $display("FAIL mid_vld got vld=%b data=%h exp 0/0", noc_in_vld, noc_in_data); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cnt[i] !== 32'd0 || rdy[i] !== 1'b0) begin errors++; $display("FAIL mid_cnt_rdy[%0d] got %0d/%b exp 0/0", i, cnt[i], rdy[i]); end
        end
        @(negedge clk);
        vld[0] = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.g_cnt[0].cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.g_cnt[0].cnt_q;
        #1;
        checks++;
        if (cnt[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pre got %h exp ffffffff", cnt[0]); end
        noc_in_rdy = 1'b1;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        checks++;
        if (cnt[0] !== 32'd0 || cnt[1] !== 32'd0) begin errors++; $display("FAIL wrap got c0=%h c1=%h exp 0/0", cnt[0], cnt[1]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_skip();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_ingress_arbiter.md
# noc_ingress_arbiter

Round-robin arbiter that shares a single NoC ingress port between `CPU_NB` CPU-to-NoC valid/ready channels. It sits between the per-CPU `data_cpu_to_noc*` channels and a single-port NoC input. Each accepted beat is registered in a one-entry output stage, tagged with its source CPU index, and presented to the NoC. Arbitration is fair: every requesting CPU is served within `CPU_NB` grants.

## Interface
- `CPU_NB`, 4, number of requesting CPUs; must be ≥ 1.
- `IDX_W`, derived, `CPU_NB > 1 ? $clog2(CPU_NB) : 1`; width of the source index.

Ports:
- `clk`  in  1  single clock; all state is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_cpu_to_noc_vld[CPU_NB]`  in  1 each  per-CPU beat valid.
- `data_cpu_to_noc_rdy[CPU_NB]`  out  1 each  per-CPU beat accepted.
- `data_cpu_to_noc[CPU_NB]`  in  64 each  per-CPU payload.
- `noc_in_vld`  out  1  output beat valid.
- `noc_in_rdy`  in  1  NoC accepts the output beat.
- `noc_in_data`  out  64  output payload.
- `noc_in_src`  out  IDX_W  index of the CPU that sent the beat.
- `grant_cnt[CPU_NB]`  out  32 each  beats accepted per CPU; wraps at 2^32.

## Operation
- **Output stage:** one register holding `noc_in_vld`, `noc_in_data` and `noc_in_src`.
- **Load enable:** `load_ok = !noc_in_vld || noc_in_rdy`.
- **Arbitration:** `rr_ptr` is an IDX_W register. The winner is the first CPU `i` with `vld[i]=1`, searching from `rr_ptr` upward with wrap at `CPU_NB-1`.
- **Ready:** `data_cpu_to_noc_rdy[winner] = load_ok`. All other `rdy` signals are 0. All `rdy` signals are 0 when no CPU is requesting or while `rst_n=0`.
- **Accept:** an accept is `vld & rdy` on the winner. On accept:
  - the output register loads the payload and `src = winner`;
  - `noc_in_vld` goes to 1;
  - `rr_ptr` becomes `winner+1`, wrapping to 0 after `CPU_NB-1`;
  - `grant_cnt[winner]` increments.
- **Drain without load:** if `noc_in_rdy=1` and there is no accept, `noc_in_vld` goes to 0. Data and src hold their last values.
- **Hold:** while `noc_in_vld=1` and `noc_in_rdy=0`, data and src are held stable and no CPU sees `rdy`.
- **No requests:** `rr_ptr` is unchanged when no CPU is requesting.
- **Arbitration states:** none beyond `rr_ptr` and the output valid bit. The output stage has two states:
  - EMPTY → FULL on accept;
  - FULL → FULL on simultaneous drain and accept;
  - FULL → EMPTY on drain with no accept.
- **CPU drops `vld` without handshake:** tolerated. The winner is recomputed every cycle.
- **CPU_NB = 1:** `rr_ptr` stays 0.

## Timing
- **Reset values:** `noc_in_vld=0`, `noc_in_data=0`, `noc_in_src=0`, `rr_ptr=0`, all `grant_cnt=0`, all `data_cpu_to_noc_rdy=0`.
- **Reset mid-operation:** a buffered beat is discarded immediately, with no handshake.
- **Latency:** accept in cycle N puts the beat on `noc_in_*` in cycle N+1.
- **Throughput:** one beat per cycle sustained when `noc_in_rdy` stays high, including back-to-back beats from different CPUs.
- **Paths:** `rdy` outputs are combinational from `vld`, `rr_ptr`, `noc_in_vld` and `noc_in_rdy`. The `noc_in_rdy` → CPU `rdy` path is the only combinational cross-port path. There is no path from any input to `noc_in_vld`, `noc_in_data` or `noc_in_src`.
- **Fairness bound:** a CPU holding `vld` waits at most `CPU_NB-1` grants to other CPUs.

## Structure
- **Shared package `noc_pkg`:** `typedef bit [63:0] noc_data_t`, and function `noc_idx_w(int n)` returning the IDX_W rule. `cpu`, `noc` and this block all import it.
- **Sub-module `rr_picker #(N)`:** purely combinational. Takes a `req` vector and a `ptr`; returns `gnt_vld` and `gnt_idx`. It is reused by the NoC egress side.
- **Top-level use:** instantiated inside `noc` in front of the single-port crossbar input.

## Test plan
1. Reset with all 4 CPUs requesting, then release `rst_n` with `noc_in_rdy=1` → accepted src order 0,1,2,3,0,…; one beat per cycle; `noc_in_vld` first high in the 2nd cycle after release.
2. CPU2 alone sends 0xDEAD_BEEF_0000_0002 → that beat appears on `noc_in_data` with `noc_in_src=2` one cycle later; `grant_cnt[2]=1`.
3. All CPUs requesting, `noc_in_rdy=0` for 5 cycles → output data/src stable, all `rdy=0`, no counter changes; resumes in round-robin order.
4. CPU1 and CPU3 requesting, `rr_ptr=2` → CPU3 granted first, then CPU1, then CPU3.
5. Assert `rst_n=0` mid-stream with a beat buffered and `noc_in_rdy=0` → `noc_in_vld` drops immediately; all `grant_cnt` read 0.
6. Preload `grant_cnt[0]` to 0xFFFF_FFFF via force, then one accept from CPU0 → counter reads 0.
